bcd_counter_bank: RTL and testbench

Parametrised multi-digit BCD counter core. It is the successor to the per-digit counter plus modeselect pair.
Adds per-digit hold-to-repeat (auto-repeat FSM), a selectable carry/borrow chain, a per-digit upper limit captured from the live count, synchronous clear, and a top-digit wrap pulse.
Sits between the input synchroniser and the display decode/shift stage. Takes one-cycle ticks from the clock scaler.

---
 rtl/bcd_counter_pkg.sv | 48 ++++
 rtl/bcd_digit_cell.sv | 95 +++++++++
 rtl/bcd_counter_bank.sv | 69 ++++++
 tb/tb_bcd_counter_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared types and the single-digit BCD step rule
// for the BCD counter bank.
package bcd_counter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rep_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef struct packed {
      logic [3:0] cnt;
      logic       carry;
   } bcd_res_t;

   // Next digit value plus carry (up) or borrow (down).
   function automatic bcd_res_t bcd_step(
      input logic [3:0] cnt,
      input logic [3:0] limit,
      input logic       up,
      input logic       lim_en
   );
      logic [3:0] top;
      bcd_res_t   r;
      top     = lim_en ? limit : BCD_MAX;
      r.cnt   = cnt;
      r.carry = 1'b0;
      if (up) begin
         if (cnt >= top) begin
            r.cnt   = 4'd0;
            r.carry = 1'b1;
         end else begin
            r.cnt = cnt + 4'd1;
         end
      end else if (cnt == 4'd0) begin
         r.cnt   = top;
         r.carry = 1'b1;
      end else if (cnt > top) begin
         r.cnt = top;
      end else begin
         r.cnt = cnt - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: hold-to-repeat FSM, repeat timer,
// count register and captured limit register.
module bcd_digit_cell
   import bcd_counter_pkg::*;
#(
   parameter int               TMR_W     = 8,
   parameter logic [TMR_W-1:0] REP_DELAY = 8'd50,
   parameter logic [TMR_W-1:0] REP_RATE  = 8'd10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       tick,
   input  logic       up_dn,
   input  logic       limit_en,
   input  logic       limit_capture,
   input  logic       clear,
   input  logic       carry_in,
   output logic [3:0] cnt,
   output logic [3:0] limit,
   output logic       carry_out,
   output logic       repeat_active
);

   rep_state_t       state;
   logic [TMR_W-1:0] timer;
   logic             btn_low_q;
   logic             press;
   logic             expire;
   logic             own_step;
   logic             step;
   bcd_res_t         nxt;

   // Edge register holds "button seen low"; it resets to 0 so a
   // button held through reset must be released before it steps.
   assign press  = btn & btn_low_q;
   assign expire = btn & tick & (timer == TMR_W'(1));

   always_comb begin
      own_step = 1'b0;
      unique case (state)
         IDLE:          own_step = press;
         DELAY, REPEAT: own_step = expire;
         default:       own_step = 1'b0;
      endcase
   end

   assign step          = own_step | carry_in;
   assign nxt           = bcd_step(cnt, limit, up_dn, limit_en);
   assign carry_out     = step & nxt.carry & ~clear;
   assign repeat_active = (state == REPEAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         btn_low_q <= 1'b0;
      end else begin
         btn_low_q <= ~btn;
         unique case (state)
            IDLE: begin
               if (press) begin
                  timer <= REP_DELAY;
                  state <= DELAY;
               end
            end
            DELAY, REPEAT: begin
               if (!btn) begin
                  state <= IDLE;
               end else if (tick) begin
                  if (timer == TMR_W'(1)) begin
                     timer <= REP_RATE;
                     state <= REPEAT;
                  end else begin
                     timer <= timer - TMR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= 4'd0;
         limit <= BCD_MAX;
      end else begin
         if (limit_capture) limit <= cnt;
         if (clear)         cnt <= 4'd0;
         else if (step)     cnt <= nxt.cnt;
      end
   end

endmodule

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD counter bank: per-digit cells with a
// combinational carry/borrow ripple and a top-digit wrap pulse.
module bcd_counter_bank
   import bcd_counter_pkg::*;
#(
   parameter int               DIGITS    = 3,
   parameter int               TMR_W     = 8,
   parameter logic [TMR_W-1:0] REP_DELAY = 8'd50,
   parameter logic [TMR_W-1:0] REP_RATE  = 8'd10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIGITS-1:0]   btn,
   input  logic                tick,
   input  logic                up_dn,
   input  logic                carry_en,
   input  logic                limit_en,
   input  logic                limit_capture,
   input  logic                clear,
   output logic [4*DIGITS-1:0] cnt_out,
   output logic [4*DIGITS-1:0] limit_out,
   output logic [DIGITS-1:0]   repeat_active,
   output logic                wrap_pulse
);

   logic top_carry;

   for (genvar j = 0; j < DIGITS; j++) begin : g_dig
      logic c_in;
      logic c_out;

      if (j == 0) begin : g_lsb
         assign c_in = 1'b0;
      end else begin : g_chain
         assign c_in = carry_en & g_dig[j-1].c_out;
      end

      if (j == DIGITS - 1) begin : g_top
         assign top_carry = c_out;
      end

      bcd_digit_cell #(
         .TMR_W     (TMR_W),
         .REP_DELAY (REP_DELAY),
         .REP_RATE  (REP_RATE)
      ) u_cell (
         .clk           (clk),
         .reset         (reset),
         .btn           (btn[j]),
         .tick          (tick),
         .up_dn         (up_dn),
         .limit_en      (limit_en),
         .limit_capture (limit_capture),
         .clear         (clear),
         .carry_in      (c_in),
         .cnt           (cnt_out[4*j +: 4]),
         .limit         (limit_out[4*j +: 4]),
         .carry_out     (c_out),
         .repeat_active (repeat_active[j])
      );
   end

   // Wrap reports the top digit regardless of carry_en.
   always_ff @(posedge clk) begin
      if (reset) wrap_pulse <= 1'b0;
      else       wrap_pulse <= top_carry;
   end

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed plus randomized bench for bcd_counter_bank against a
// hold-time based reference model.
module tb_bcd_counter_bank;

   localparam int D = 50;
   localparam int R = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  btn;
   logic        tick;
   logic        up_dn;
   logic        carry_en;
   logic        limit_en;
   logic        limit_capture;
   logic        clear;
   logic [11:0] cnt_out;
   logic [11:0] limit_out;
   logic [2:0]  repeat_active;
   logic        wrap_pulse;

   int errors = 0;
   int checks = 0;

   int m_cnt[3];
   int m_lim[3];
   int m_nt[3];
   bit m_held[3];
   bit m_low[3];
   bit m_wrap;

   bcd_counter_bank #(
      .DIGITS    (3),
      .TMR_W     (8),
      .REP_DELAY (8'd50),
      .REP_RATE  (8'd10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn),
      .tick          (tick),
      .up_dn         (up_dn),
      .carry_en      (carry_en),
      .limit_en      (limit_en),
      .limit_capture (limit_capture),
      .clear         (clear),
      .cnt_out       (cnt_out),
      .limit_out     (limit_out),
      .repeat_active (repeat_active),
      .wrap_pulse    (wrap_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs,
                      input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a step fires on a fresh press, after D held ticks,
   // then every R held ticks; digits use plain decimal arithmetic.
   task automatic model_cycle();
      int old[3];
      bit own[3];
      bit cy;
      bit st;
      int lv;
      if (reset) begin
         for (int j = 0; j < 3; j++) begin
            m_cnt[j] = 0; m_lim[j] = 9; m_nt[j] = 0;
            m_held[j] = 0; m_low[j] = 0;
         end
         m_wrap = 0;
         return;
      end
      for (int j = 0; j < 3; j++) begin
         own[j] = 0;
         if (btn[j] && m_low[j]) begin
            own[j] = 1; m_held[j] = 1; m_nt[j] = 0;
         end else if (!btn[j]) begin
            m_held[j] = 0;
         end else if (m_held[j] && tick) begin
            m_nt[j]++;
            if (m_nt[j] == D || (m_nt[j] > D && (m_nt[j] - D) % R == 0))
               own[j] = 1;
         end
         m_low[j] = !btn[j];
         old[j] = m_cnt[j];
      end
      cy = 0;
      for (int j = 0; j < 3; j++) begin
         st = own[j] || (carry_en && cy);
         cy = 0;
         lv = limit_en ? m_lim[j] : 9;
         if (st) begin
            if (up_dn) begin
               if (old[j] >= lv) begin m_cnt[j] = 0; cy = 1; end
               else m_cnt[j] = old[j] + 1;
            end else if (old[j] == 0) begin
               m_cnt[j] = lv; cy = 1;
            end else if (old[j] > lv) begin
               m_cnt[j] = lv;
            end else begin
               m_cnt[j] = old[j] - 1;
            end
         end
      end
      m_wrap = cy && !clear;
      if (clear) for (int j = 0; j < 3; j++) m_cnt[j] = 0;
      if (limit_capture) for (int j = 0; j < 3; j++) m_lim[j] = old[j];
   endtask

   task automatic run(input int n);
      logic [11:0] ec, el;
      logic [2:0]  er;
      for (int k = 0; k < n; k++) begin
         model_cycle();
         @(posedge clk);
         #1;
         for (int j = 0; j < 3; j++) begin
            ec[4*j +: 4] = 4'(m_cnt[j]);
            el[4*j +: 4] = 4'(m_lim[j]);
            er[j] = m_held[j] && (m_nt[j] >= D);
         end
         chk("cnt", cnt_out, ec);
         chk("limit", limit_out, el);
         chk("repeat", 12'(repeat_active), 12'(er));
         chk("wrap", 12'(wrap_pulse), 12'(m_wrap));
      end
   endtask

   task automatic press(input logic [2:0] m);
      btn = m;
      run(1);
      btn = 3'b000;
      run(1);
   endtask

   initial begin
      reset = 1; btn = 0; tick = 0; up_dn = 1; carry_en = 0;
      limit_en = 0; limit_capture = 0; clear = 0;
      run(2);
      reset = 0;
      run(1);
      chk("rst_cnt", cnt_out, 12'h000);
      chk("rst_limit", limit_out, 12'h999);

      // single press, no repeat
      btn = 3'b001;
      run(1);
      chk("press_one", cnt_out, 12'h001);
      btn = 3'b000;
      run(3);
      chk("press_stays", cnt_out, 12'h001);

      // hold digit 1: press + 1 delay step + 3 repeat steps over 80 ticks
      btn = 3'b010;
      for (int i = 0; i < 320; i++) begin
         tick = (i % 4 == 3);
         run(1);
      end
      chk("hold_cnt", cnt_out, 12'h051);
      chk("hold_act", 12'(repeat_active), 12'h002);
      tick = 0; btn = 3'b000;
      run(1);
      chk("rel_act", 12'(repeat_active), 12'h000);
      for (int i = 0; i < 40; i++) begin
         tick = (i % 4 == 3);
         run(1);
      end
      tick = 0;
      chk("rel_cnt", cnt_out, 12'h051);

      // full ripple and wrap
      clear = 1; run(1); clear = 0;
      chk("clear", cnt_out, 12'h000);
      up_dn = 0;
      press(3'b111);
      chk("to_999", cnt_out, 12'h999);
      carry_en = 1; up_dn = 1; btn = 3'b001;
      run(1);
      chk("ripple", cnt_out, 12'h000);
      chk("wrap_hi", 12'(wrap_pulse), 12'h001);
      btn = 3'b000;
      run(1);
      chk("wrap_lo", 12'(wrap_pulse), 12'h000);
      carry_en = 0; up_dn = 0;
      press(3'b111);
      up_dn = 1; btn = 3'b001;
      run(1);
      chk("no_chain", cnt_out, 12'h990);
      chk("no_wrap", 12'(wrap_pulse), 12'h000);
      btn = 3'b000;
      run(1);

      // captured limit
      clear = 1; run(1); clear = 0;
      press(3'b010); press(3'b010);
      for (int i = 0; i < 5; i++) press(3'b001);
      chk("set_025", cnt_out, 12'h025);
      limit_capture = 1; run(1); limit_capture = 0;
      chk("capture", limit_out, 12'h025);
      limit_en = 1;
      clear = 1; run(1); clear = 0;
      up_dn = 0;
      press(3'b001);
      chk("lim_down", cnt_out, 12'h005);
      up_dn = 1;
      press(3'b010);
      carry_en = 1; btn = 3'b001;
      run(1);
      chk("lim_up", cnt_out, 12'h020);
      btn = 3'b000;
      run(1);
      press(3'b100);
      chk("lim_zero", cnt_out, 12'h020);
      limit_en = 0; carry_en = 0;

      // own step and carry-in together
      clear = 1; run(1); clear = 0;
      press(3'b010);
      for (int i = 0; i < 9; i++) press(3'b001);
      chk("set_019", cnt_out, 12'h019);
      carry_en = 1; btn = 3'b011;
      run(1);
      chk("single_step", cnt_out, 12'h020);
      btn = 3'b000; carry_en = 0;
      run(1);

      // reset mid-REPEAT with the button held
      clear = 1; run(1); clear = 0;
      tick = 1; btn = 3'b100;
      run(60);
      chk("pre_rst_act", 12'(repeat_active), 12'h004);
      reset = 1; run(1); reset = 0;
      chk("mid_rst_cnt", cnt_out, 12'h000);
      chk("mid_rst_act", 12'(repeat_active), 12'h000);
      run(30);
      chk("held_no_step", cnt_out, 12'h000);
      btn = 3'b000; run(1);
      btn = 3'b100; run(1);
      chk("repress", cnt_out, 12'h100);
      btn = 3'b000; tick = 0;
      run(1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         for (int j = 0; j < 3; j++)
            if ($urandom_range(99) == 0) btn[j] = ~btn[j];
         if ($urandom_range(19) == 0) btn = 3'($urandom);
         tick = 1'($urandom);
         if ($urandom_range(49) == 0) up_dn = ~up_dn;
         if ($urandom_range(29) == 0) carry_en = ~carry_en;
         if ($urandom_range(39) == 0) limit_en = ~limit_en;
         limit_capture = ($urandom_range(24) == 0);
         clear = ($urandom_range(59) == 0);
         reset = ($urandom_range(499) == 0);
         run(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
